lane_mux_scheduler: RTL and testbench

// Schedules four 9-bit byte lanes (bit8 = valid, [7:0] = byte) onto one shared 9-bit output lane at clk4f.

---
 rtl/lane_mux_scheduler_pkg.sv | 39 +++
 rtl/lane_mux_scheduler_fifo.sv | 55 +++++
 rtl/lane_mux_scheduler.sv | 111 +++++++++++
 tb/tb_lane_mux_scheduler.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lane_mux_scheduler_pkg.sv
// Shared lane geometry, mode encodings and the round-robin search helper
// used by the lane multiplexing scheduler.
package lane_mux_scheduler_pkg;

    localparam int LANES     = 4;
    localparam int LANE_W    = 9;
    localparam int VALID_BIT = 8;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

    typedef logic [1:0] lane_idx_t;

    typedef struct packed {
        logic      found;
        lane_idx_t lane;
    } grant_t;

    // First non-empty lane at or after ptr, wrapping; scanning from the far
    // end lets the nearest candidate overwrite earlier hits.
    function automatic grant_t rr_search(input logic [LANES-1:0] nonempty,
                                         input lane_idx_t        ptr);
        grant_t    g;
        lane_idx_t idx;
        g.found = 1'b0;
        g.lane  = ptr;
        for (int k = LANES - 1; k >= 0; k--) begin
            idx = ptr + lane_idx_t'(k);
            if (nonempty[idx]) begin
                g.found = 1'b1;
                g.lane  = idx;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/lane_mux_scheduler_fifo.sv
// Per-lane byte FIFO: wrap-around pointers, occupancy count 0..DEPTH,
// flags derived from the registered count only.
module lane_fifo #(
    parameter int DEPTH = 2
) (
    input  logic       clk4f,
    input  logic       reset,
    input  logic       i_push,
    input  logic       i_pop,
    input  logic [7:0] i_din,
    output logic       o_full,
    output logic       o_empty,
    output logic [7:0] o_dout
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [7:0]       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    // A full FIFO refuses the push even when it is being popped this edge.
    assign w_push_ok = i_push & ~o_full;
    assign w_pop_ok  = i_pop & ~o_empty;
    assign o_dout    = r_mem[r_rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk4f or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage has no reset; the cleared count makes stale contents unreachable.
    always_ff @(posedge clk4f) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_din;
    end

endmodule

// File: rtl/lane_mux_scheduler.sv
// Schedules four buffered byte lanes onto one registered output lane using
// either fixed TDM slots or work-conserving round-robin.
module lane_mux_scheduler
    import lane_mux_scheduler_pkg::*;
#(
    parameter int         DEPTH     = 2,
    parameter logic [7:0] IDLE_BYTE = 8'h00
) (
    input  logic              clk4f,
    input  logic              reset,
    input  logic              mode_rr,
    input  logic [LANE_W-1:0] data0,
    input  logic [LANE_W-1:0] data1,
    input  logic [LANE_W-1:0] data2,
    input  logic [LANE_W-1:0] data3,
    output logic              in_ready0,
    output logic              in_ready1,
    output logic              in_ready2,
    output logic              in_ready3,
    input  logic              out_ready,
    output logic [LANE_W-1:0] data_out,
    output logic [1:0]        lane_out
);

    logic [LANE_W-1:0] w_data [LANES];
    logic [7:0]        w_dout [LANES];
    logic [LANES-1:0]  w_full;
    logic [LANES-1:0]  w_empty;
    logic [LANES-1:0]  w_pop;

    mode_e             r_mode;
    lane_idx_t         r_slot;
    lane_idx_t         r_ptr;

    mode_e             w_mode_in;
    lane_idx_t         w_slot_cur;
    lane_idx_t         w_slot_nxt;
    lane_idx_t         w_ptr_nxt;
    lane_idx_t         w_lane_nxt;
    logic [LANE_W-1:0] w_data_nxt;
    grant_t            w_grant;

    assign w_data[0] = data0;
    assign w_data[1] = data1;
    assign w_data[2] = data2;
    assign w_data[3] = data3;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        lane_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk4f   (clk4f),
            .reset   (reset),
            .i_push  (w_data[gi][VALID_BIT]),
            .i_pop   (w_pop[gi]),
            .i_din   (w_data[gi][7:0]),
            .o_full  (w_full[gi]),
            .o_empty (w_empty[gi]),
            .o_dout  (w_dout[gi])
        );
    end

    assign in_ready0 = ~w_full[0];
    assign in_ready1 = ~w_full[1];
    assign in_ready2 = ~w_full[2];
    assign in_ready3 = ~w_full[3];

    // The mode input sampled at this advance selects the policy; leaving RR
    // for FIXED serves slot 0 on that same advance.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_mode_in  = mode_e'(mode_rr);
        w_slot_cur = (r_mode == MODE_RR && w_mode_in == MODE_FIXED) ? '0 : r_slot;
        w_grant    = rr_search(~w_empty, r_ptr);
        w_data_nxt = {1'b0, IDLE_BYTE};
        w_lane_nxt = w_slot_cur;
        w_slot_nxt = r_slot;
        w_ptr_nxt  = r_ptr;
        w_pop      = '0;
        if (w_mode_in == MODE_FIXED) begin
            w_slot_nxt = w_slot_cur + 2'd1;
            if (!w_empty[w_slot_cur]) begin
                w_pop[w_slot_cur] = out_ready;
                w_data_nxt        = {1'b1, w_dout[w_slot_cur]};
            end
        end else begin
            w_lane_nxt = r_ptr;
            if (w_grant.found) begin
                w_lane_nxt          = w_grant.lane;
                w_ptr_nxt           = w_grant.lane + 2'd1;
                w_pop[w_grant.lane] = out_ready;
                w_data_nxt          = {1'b1, w_dout[w_grant.lane]};
            end
        end
    end

    always_ff @(posedge clk4f or posedge reset) begin
        if (reset) begin
            r_mode   <= MODE_FIXED;
            r_slot   <= '0;
            r_ptr    <= '0;
            data_out <= {1'b0, IDLE_BYTE};
            lane_out <= '0;
        end else if (out_ready) begin
            r_mode   <= w_mode_in;
            r_slot   <= w_slot_nxt;
            r_ptr    <= w_ptr_nxt;
            data_out <= w_data_nxt;
            lane_out <= w_lane_nxt;
        end
    end

endmodule

// File: tb/tb_lane_mux_scheduler.sv
// Self-checking bench: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_lane_mux_scheduler;

    localparam int         DEPTH = 2;
    localparam logic [7:0] IDLE  = 8'h00;

    logic       clk4f = 1'b0;
    logic       reset;
    logic       mode_rr;
    logic       out_ready;
    logic [8:0] d [4];
    logic [3:0] rdy;
    logic [8:0] data_out;
    logic [1:0] lane_out;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    // Reference model state.
    logic [7:0] m_q [4][$];
    int         m_prev_mode;
    int         m_slot;
    int         m_ptr;
    logic [8:0] m_dout;
    logic [1:0] m_lane;

    lane_mux_scheduler #(.DEPTH(DEPTH), .IDLE_BYTE(IDLE)) dut (
        .clk4f     (clk4f),
        .reset     (reset),
        .mode_rr   (mode_rr),
        .data0     (d[0]),
        .data1     (d[1]),
        .data2     (d[2]),
        .data3     (d[3]),
        .in_ready0 (rdy[0]),
        .in_ready1 (rdy[1]),
        .in_ready2 (rdy[2]),
        .in_ready3 (rdy[3]),
        .out_ready (out_ready),
        .data_out  (data_out),
        .lane_out  (lane_out)
    );

    always #5 clk4f = ~clk4f;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] m_ready();
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = (m_q[i].size() < DEPTH);
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_q[i].delete();
        m_prev_mode = 0;
        m_slot      = 0;
        m_ptr       = 0;
        m_dout      = {1'b0, IDLE};
        m_lane      = 2'd0;
    endtask

    // One clock edge of the scheduler, written from the behavioural rules.
    task automatic model_step();
        bit accept [4];
        int s;
        int g;
        bit found;
        for (int i = 0; i < 4; i++) accept[i] = d[i][8] && (m_q[i].size() < DEPTH);
        if (out_ready) begin
            if (mode_rr == 1'b0) begin
                s      = (m_prev_mode == 1) ? 0 : m_slot;
                m_lane = 2'(s);
                if (m_q[s].size() > 0) m_dout = {1'b1, m_q[s].pop_front()};
                else                   m_dout = {1'b0, IDLE};
                m_slot = (s + 1) % 4;
            end else begin
                found = 1'b0;
                g     = 0;
                for (int k = 0; k < 4; k++) begin
                    if (!found && m_q[(m_ptr + k) % 4].size() > 0) begin
                        found = 1'b1;
                        g     = (m_ptr + k) % 4;
                    end
                end
                if (found) begin
                    m_dout = {1'b1, m_q[g].pop_front()};
                    m_lane = 2'(g);
                    m_ptr  = (g + 1) % 4;
                end else begin
                    m_dout = {1'b0, IDLE};
                    m_lane = 2'(m_ptr);
                end
            end
            m_prev_mode = int'(mode_rr);
        end
        for (int i = 0; i < 4; i++) if (accept[i]) m_q[i].push_back(d[i][7:0]);
    endtask

    task automatic step();
        @(posedge clk4f);
        model_step();
        #2;
    endtask

    task automatic tick(input logic [8:0] a0, input logic [8:0] a1, input logic [8:0] a2,
                        input logic [8:0] a3, input logic ordy, input logic mrr);
        d[0]      = a0;
        d[1]      = a1;
        d[2]      = a2;
        d[3]      = a3;
        out_ready = ordy;
        mode_rr   = mrr;
        step();
    endtask

    task automatic expect_out(input string name, input logic [8:0] ed, input logic [1:0] el);
        check({name, "_data"}, 16'(data_out), 16'(ed));
        check({name, "_lane"}, 16'(lane_out), 16'(el));
    endtask

    // Asynchronous reset asserted between edges, held over two edges.
    task automatic do_reset(input string name);
        for (int i = 0; i < 4; i++) d[i] = 9'h000;
        out_ready = 1'b0;
        #1;
        reset = 1'b1;
        model_reset();
        #1;
        check({name, "_data"}, 16'(data_out), 16'h0000);
        check({name, "_lane"}, 16'(lane_out), 16'h0000);
        check({name, "_rdy"},  16'(rdy),      16'h000f);
        @(posedge clk4f);
        @(posedge clk4f);
        #2;
        reset = 1'b0;
    endtask

    // Cycle-by-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk4f);
            if (chk_en && !reset) begin
                check("cyc_data_out", 16'(data_out), 16'(m_dout));
                check("cyc_lane_out", 16'(lane_out), 16'(m_lane));
                check("cyc_in_ready", 16'(rdy),      16'(m_ready()));
            end
        end
    end

    initial begin
        reset     = 1'b1;
        mode_rr   = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) d[i] = 9'h000;
        model_reset();
        #1;
        expect_out("rst", 9'h000, 2'd0);
        check("rst_rdy", 16'(rdy), 16'h000f);
        @(posedge clk4f);
        @(posedge clk4f);
        #2;
        reset  = 1'b0;
        chk_en = 1'b1;

        // Fixed mode: one word per lane drains in slot order.
        tick(9'h100, 9'h101, 9'h102, 9'h103, 1'b0, 1'b0);
        tick(9'h000, 9'h000, 9'h000, 9'h000, 1'b1, 1'b0);
        expect_out("fx0", 9'h100, 2'd0);
        tick(9'h000, 9'h000, 9'h000, 9'h000, 1'b1, 1'b0);
        expect_out("fx1", 9'h101, 2'd1);
        tick(9'h000, 9'h000, 9'h000, 9'h000, 1'b1, 1'b0);
        expect_out("fx2", 9'h102, 2'd2);
        tick(9'h000, 9'h000, 9'h000, 9'h000, 1'b1, 1'b0);
        expect_out("fx3", 9'h103, 2'd3);

        // Fixed mode: idle slots are not skipped.
        tick(9'h000, 9'h000, 9'h1AA, 9'h000, 1'b0, 1'b0);
        tick(9'h000, 9'h000, 9'h000, 9'h000, 1'b1, 1'b0);
        expect_out("idl0", 9'h000, 2'd0);
        tick(9'h000, 9'h000, 9'h000, 9'h000, 1'b1, 1'b0);
        expect_out("idl1", 9'h000, 2'd1);
        tick(9'h000, 9'h000, 9'h000, 9'h000, 1'b1, 1'b0);
        expect_out("idl2", 9'h1AA, 2'd2);
        tick(9'h000, 9'h000, 9'h000, 9'h000, 1'b1, 1'b0);
        expect_out("idl3", 9'h000, 2'd3);

        // Round-robin alternates between the two busy lanes.
        tick(9'h000, 9'h1A1, 9'h000, 9'h1B1, 1'b0, 1'b1);
        tick(9'h000, 9'h1A2, 9'h000, 9'h1B2, 1'b0, 1'b1);
        tick(9'h000, 9'h000, 9'h000, 9'h000, 1'b1, 1'b1);
        expect_out("rr0", 9'h1A1, 2'd1);
        tick(9'h000, 9'h000, 9'h000, 9'h000, 1'b1, 1'b1);
        expect_out("rr1", 9'h1B1, 2'd3);
        tick(9'h000, 9'h000, 9'h000, 9'h000, 1'b1, 1'b1);
        expect_out("rr2", 9'h1A2, 2'd1);
        tick(9'h000, 9'h000, 9'h000, 9'h000, 1'b1, 1'b1);
        expect_out("rr3", 9'h1B2, 2'd3);
        tick(9'h000, 9'h000, 9'h000, 9'h000, 1'b1, 1'b1);
        expect_out("rr4", 9'h000, 2'd0);

        // Back-pressure: lane 0 fills, output holds, then drains in order.
        tick(9'h110, 9'h000, 9'h000, 9'h000, 1'b0, 1'b0);
        check("bp_rdy0_a", 16'(rdy[0]), 16'h0001);
        tick(9'h111, 9'h000, 9'h000, 9'h000, 1'b0, 1'b0);
        check("bp_rdy0_b", 16'(rdy[0]), 16'h0000);
        tick(9'h112, 9'h000, 9'h000, 9'h000, 1'b0, 1'b0);
        tick(9'h113, 9'h000, 9'h000, 9'h000, 1'b0, 1'b0);
        tick(9'h114, 9'h000, 9'h000, 9'h000, 1'b0, 1'b0);
        expect_out("bp_hold", 9'h000, 2'd0);
        check("bp_rdy0_c", 16'(rdy[0]), 16'h0000);
        tick(9'h000, 9'h000, 9'h000, 9'h000, 1'b1, 1'b0);
        expect_out("bp_d0", 9'h110, 2'd0);
        for (int i = 0; i < 3; i++) tick(9'h000, 9'h000, 9'h000, 9'h000, 1'b1, 1'b0);
        tick(9'h000, 9'h000, 9'h000, 9'h000, 1'b1, 1'b0);
        expect_out("bp_d1", 9'h111, 2'd0);

        // Full lane popped and pushed at one edge: the push is refused.
        tick(9'h000, 9'h121, 9'h000, 9'h000, 1'b0, 1'b0);
        tick(9'h000, 9'h122, 9'h000, 9'h000, 1'b0, 1'b0);
        check("full_rdy1_a", 16'(rdy[1]), 16'h0000);
        tick(9'h000, 9'h123, 9'h000, 9'h000, 1'b1, 1'b0);
        expect_out("full_pop", 9'h121, 2'd1);
        check("full_rdy1_b", 16'(rdy[1]), 16'h0001);
        for (int i = 0; i < 3; i++) tick(9'h000, 9'h000, 9'h000, 9'h000, 1'b1, 1'b0);
        tick(9'h000, 9'h000, 9'h000, 9'h000, 1'b1, 1'b0);
        expect_out("full_next", 9'h122, 2'd1);
        for (int i = 0; i < 3; i++) tick(9'h000, 9'h000, 9'h000, 9'h000, 1'b1, 1'b0);
        tick(9'h000, 9'h000, 9'h000, 9'h000, 1'b1, 1'b0);
        expect_out("full_gone", 9'h000, 2'd1);

        // Reset mid-stream with every FIFO full.
        tick(9'h130, 9'h131, 9'h132, 9'h133, 1'b0, 1'b1);
        tick(9'h134, 9'h135, 9'h136, 9'h137, 1'b0, 1'b1);
        tick(9'h000, 9'h000, 9'h000, 9'h000, 1'b1, 1'b1);
        do_reset("mid_rst");
        for (int i = 0; i < 4; i++) begin
            tick(9'h000, 9'h000, 9'h000, 9'h000, 1'b1, 1'b1);
            check("no_stale", 16'(data_out[8]), 16'h0000);
        end

        // Randomized traffic with mode flips, back-pressure and one reset.
        begin
            logic mr;
            mr = 1'b0;
            for (int c = 0; c < 3000; c++) begin
                if (c == 1500) do_reset("rnd_rst");
                if ($urandom_range(0, 15) == 0) mr = ~mr;
                for (int i = 0; i < 4; i++) d[i] = {1'($urandom_range(0, 1)), 8'($urandom)};
                out_ready = ($urandom_range(0, 9) < 7);
                mode_rr   = mr;
                step();
            end
        end

        @(negedge clk4f);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
